spimaster: RTL
==============

Name: spimaster

Overview:
SPI master and the controller-side counterpart of the router's SPI slave. Both use the same mode: CKP=0, CKE=0, SCK idle low, data driven on SCK rising, sampled on SCK falling, MSB first, 8-bit frames, SS active-low.
- Generates SCK and SS from the system clock.
- Shifts out one byte and captures the returned byte.
- Signals completion with a one-cycle rdy pulse.
- Used by the MIDI router core to exchange bytes with SPI peripherals and host-side slaves.

Parameters:
DIV, 4, SCK half-period in clk cycles (>=1)
LEAD, 2, clk cycles SS low before first SCK rising edge (>=1)
TRAIL, 2, clk cycles after last SCK falling edge before SS deasserts (>=1)
GAP, 2, minimum clk cycles SS high between frames (>=1)

Ports:
clk     in   1  system clock; all logic on its rising edge
rst     in   1  synchronous, active-high reset
sck     out  1  SPI clock, idle low
sdo     out  1  MOSI
sdi     in   1  MISO, already synchronous to clk
ss      out  1  slave select, active low
data_i  in   8  byte to transmit, captured when ld accepted
data_o  out  8  last received byte, valid from rdy onward until the next rdy
ld      in   1  start request, single-cycle or level
rdy     out  1  one-cycle pulse: frame complete, data_o updated
busy    out  1  high whenever state != IDLE

Behaviour:
- Single clock, synchronous active-high reset. All outputs registered.
- Reset values: sck=0, ss=1, sdo=0, rdy=0, busy=0, data_o=0x00, state=IDLE. Reset mid-frame aborts immediately; next cycle shows reset values. No rdy is produced for an aborted frame.
- State machine: IDLE, LEAD, SCK_HI, SCK_LO, TRAIL, GAP. A single down-counter times every state; each state lasts exactly its parameter count.
- IDLE: ss=1, sck=0. When ld=1 at edge N:
  - tx_sr<=data_i, bitcnt<=0.
  - ss=0 from N+1.
  - Go to LEAD.
- ld is ignored in every state except IDLE; no queuing.
- LEAD (LEAD cycles): then sck<=1, sdo<=tx_sr[7], go to SCK_HI.
- SCK_HI (DIV cycles): then:
  - sck<=0, rx_sr<={rx_sr[6:0],sdi}, bitcnt++.
  - If bitcnt was 7, go to TRAIL; otherwise go to SCK_LO.
- SCK_LO (DIV cycles): then tx_sr<<=1, sck<=1, sdo<=new tx_sr[7], go to SCK_HI.
- TRAIL (TRAIL cycles): then ss<=1, data_o<=rx_sr, rdy<=1 for exactly one cycle, go to GAP.
- GAP (GAP cycles, ss high): then go to IDLE. This guarantees the slave sees an SS rising edge plus a setup interval.
- Timing, with t0 = N+1+LEAD:
  - Bit k rises at t0+2k*DIV and falls at t0+(2k+1)*DIV.
  - SS rises and rdy pulses at t0+15*DIV+TRAIL.
  - busy falls GAP cycles later.
  - Defaults: SCK first rise N+3, last fall N+63, rdy/ss-high N+65, busy low N+67; next ld is accepted at N+67.
- Exactly 8 rising and 8 falling SCK edges per frame. SCK never toggles while ss=1.
- sdo holds the last driven bit after the frame. It is don't-care to the slave but must be deterministic: it keeps its value.
- ld held high continuously produces back-to-back frames separated by exactly GAP+1 cycles of ss high, counted from ss rise to the next ss fall.
- If rst and ld are high in the same cycle, rst wins.

Decomposition:
- Shared package spi_pkg:
  - State encoding (3-bit).
  - Frame width constant (8).
  - Mode constants (CKP=0, CKE=0) shared with the slave.
- No sub-module. The single timing down-counter and bit counter stay inline; the block is one FSM with a datapath.

Test Plan:
1. Reset: assert rst for 3 cycles mid-frame (during SCK_HI of bit 3) -> next cycle sck=0, ss=1, busy=0, rdy=0, data_o unchanged from reset (0x00); no rdy afterwards.
2. Single frame with defaults: data_i=0xA5 and a slave model returning 0x3C -> sdo shows 1,0,1,0,0,1,0,1 at SCK rises N+3+8k; rdy at N+65 with data_o=0x3C; ss low N+1..N+64; busy low at N+67.
3. Loopback sdo->sdi with DIV=1, LEAD=1, TRAIL=1, GAP=1, data_i=0xFF then 0x00 -> data_o=0xFF, then 0x00; exactly 8 SCK rising edges per frame counted.
4. ld pulsed during busy (at LEAD, mid-bits, TRAIL, GAP) -> ignored; only one frame and one rdy; data_i changes after acceptance do not alter transmitted bits.
5. ld held high for 3 frames with data_i=0x01, 0x80, 0x55 and a spislave instance connected -> slave shift register holds each byte at its ss rise; ss high for exactly GAP+1 cycles between frames.
6. Protocol checker assertions throughout: sck stays 0 when ss=1; sdo changes only on cycles where sck rises, or stays stable; rdy is never high on two consecutive cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, frame width and master state encoding.
package spi_pkg;

  localparam int FRAME_W = 8;

  // Mode 0: SCK idles low (CKP=0), data launched on rise and captured on fall (CKE=0).
  localparam logic CKP = 1'b0;
  localparam logic CKE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_SCK_HI = 3'd2,
    ST_SCK_LO = 3'd3,
    ST_TRAIL  = 3'd4,
    ST_GAP    = 3'd5
  } spi_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spimaster_if.sv
// Byte handshake plus SPI pins of the SPI master; "slave" is the user/peripheral side.
interface spimaster_if;
  import spi_pkg::*;

  logic               sck;
  logic               sdo;
  logic               sdi;
  logic               ss;
  logic [FRAME_W-1:0] data_i;
  logic [FRAME_W-1:0] data_o;
  logic               ld;
  logic               rdy;
  logic               busy;

  modport master (
    output sck, sdo, ss, data_o, rdy, busy,
    input  sdi, data_i, ld
  );

  modport slave (
    input  sck, sdo, ss, data_o, rdy, busy,
    output sdi, data_i, ld
  );

endinterface

// File: rtl/spimaster.sv
// Mode-0 SPI master: one byte per frame, SS/SCK timed by a single down-counter.
module spimaster
  import spi_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int LEAD  = 2,
  parameter int TRAIL = 2,
  parameter int GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  spimaster_if.master bus
);

  localparam int CNT_MAX = max4(DIV, LEAD, TRAIL, GAP);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [BIT_W-1:0] bit_t;

  // Counter reload values: every state lasts exactly its parameter in clk cycles.
  localparam cnt_t DIV_LD   = cnt_t'(DIV - 1);
  localparam cnt_t LEAD_LD  = cnt_t'(LEAD - 1);
  localparam cnt_t TRAIL_LD = cnt_t'(TRAIL - 1);
  localparam cnt_t GAP_LD   = cnt_t'(GAP - 1);
  localparam bit_t LAST_BIT = bit_t'(FRAME_W - 1);

  spi_state_e         state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  bit_t               bitcnt_q, bitcnt_d;
  logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
  logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
  logic [FRAME_W-1:0] data_o_q, data_o_d;
  logic               sck_q, sck_d;
  logic               sdo_q, sdo_d;
  logic               ss_q, ss_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic               cnt_last;

  assign cnt_last = (cnt_q == '0);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      data_o_q <= '0;
      sck_q    <= CKP;
      sdo_q    <= 1'b0;
      ss_q     <= 1'b1;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      data_o_q <= data_o_d;
      sck_q    <= sck_d;
      sdo_q    <= sdo_d;
      ss_q     <= ss_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    data_o_d = data_o_q;
    sck_d    = sck_q;
    sdo_d    = sdo_q;
    ss_d     = ss_q;
    rdy_d    = 1'b0;

    if (state_q != ST_IDLE && !cnt_last) cnt_d = cnt_q - 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ld) begin
          tx_sr_d  = bus.data_i;
          bitcnt_d = '0;
          ss_d     = 1'b0;
          cnt_d    = LEAD_LD;
          state_d  = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (cnt_last) begin
          sck_d   = ~CKP;
          sdo_d   = tx_sr_q[FRAME_W-1];
          cnt_d   = DIV_LD;
          state_d = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        if (cnt_last) begin
          sck_d    = CKP;
          rx_sr_d  = {rx_sr_q[FRAME_W-2:0], bus.sdi};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            cnt_d   = TRAIL_LD;
            state_d = ST_TRAIL;
          end else begin
            cnt_d   = DIV_LD;
            state_d = ST_SCK_LO;
          end
        end
      end
      ST_SCK_LO: begin
        if (cnt_last) begin
          // The bit launched now is the MSB of the shifted register.
          tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
          sck_d   = ~CKP;
          sdo_d   = tx_sr_q[FRAME_W-2];
          cnt_d   = DIV_LD;
          state_d = ST_SCK_HI;
        end
      end
      ST_TRAIL: begin
        if (cnt_last) begin
          ss_d     = 1'b1;
          data_o_d = rx_sr_q;
          rdy_d    = 1'b1;
          cnt_d    = GAP_LD;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.sck    = sck_q;
  assign bus.sdo    = sdo_q;
  assign bus.ss     = ss_q;
  assign bus.rdy    = rdy_q;
  assign bus.busy   = busy_q;
  assign bus.data_o = data_o_q;

endmodule
